// File: rtl/seg7_display_capture_pkg.sv
// Shared definitions for the seven-segment display driver and its capture
// (reader) block: segment pattern type, hex glyph constants, digit count and
// a one-hot index helper.
package seg7_pkg;

    localparam int NUM_DIGITS = 8;

    // Segment pattern in gfedcba order, active-high (1 = segment lit).
    typedef logic [6:0] seg_t;
    typedef logic [3:0] nibble_t;

    localparam seg_t SEG_BLANK = 7'h00;
    localparam seg_t SEG_0     = 7'h3F;
    localparam seg_t SEG_1     = 7'h06;
    localparam seg_t SEG_2     = 7'h5B;
    localparam seg_t SEG_3     = 7'h4F;
    localparam seg_t SEG_4     = 7'h66;
    localparam seg_t SEG_5     = 7'h6D;
    localparam seg_t SEG_6     = 7'h7D;
    localparam seg_t SEG_7     = 7'h07;
    localparam seg_t SEG_8     = 7'h7F;
    localparam seg_t SEG_9     = 7'h6F;
    localparam seg_t SEG_A     = 7'h77;
    localparam seg_t SEG_B     = 7'h7C;
    localparam seg_t SEG_C     = 7'h39;
    localparam seg_t SEG_D     = 7'h5E;
    localparam seg_t SEG_E     = 7'h79;
    localparam seg_t SEG_F     = 7'h71;

    // Index of the set bit in a one-hot anode vector. Only meaningful when
    // exactly one bit is set; the caller qualifies with a popcount.
    function automatic logic [2:0] onehot_index(input logic [NUM_DIGITS-1:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (v[i]) idx = i[2:0];
        end
        return idx;
    endfunction

endpackage

// File: rtl/seg7_display_capture_if.sv
// Multiplexed seven-segment display bus. All lines are active-low as seen
// on the board: segX = 0 lights a segment, anN = 0 selects digit N.
// The display driver owns the bus (master); the capture block listens (slave).
interface seg7_display_capture_if;

    logic segA, segB, segC, segD, segE, segF, segG;
    logic an0, an1, an2, an3, an4, an5, an6, an7;

    modport master (
        output segA, segB, segC, segD, segE, segF, segG,
        output an0, an1, an2, an3, an4, an5, an6, an7
    );

    modport slave (
        input segA, segB, segC, segD, segE, segF, segG,
        input an0, an1, an2, an3, an4, an5, an6, an7
    );

endinterface

// File: rtl/seg7_display_capture_decode.sv
// Combinational decode of an active-high segment pattern back to a hex
// nibble. The all-off pattern is reported as blank; anything that is neither
// blank nor one of the 16 hex glyphs is reported as invalid.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  seg_t    pat,
    output nibble_t nibble,
    output logic    is_blank,
    output logic    is_invalid
);

    // Glyph lookup; invalid patterns leave the nibble at zero.
    always_comb begin
        nibble     = 4'h0;
        is_blank   = 1'b0;
        is_invalid = 1'b0;
        case (pat)
            SEG_0:     nibble = 4'h0;
            SEG_1:     nibble = 4'h1;
            SEG_2:     nibble = 4'h2;
            SEG_3:     nibble = 4'h3;
            SEG_4:     nibble = 4'h4;
            SEG_5:     nibble = 4'h5;
            SEG_6:     nibble = 4'h6;
            SEG_7:     nibble = 4'h7;
            SEG_8:     nibble = 4'h8;
            SEG_9:     nibble = 4'h9;
            SEG_A:     nibble = 4'hA;
            SEG_B:     nibble = 4'hB;
            SEG_C:     nibble = 4'hC;
            SEG_D:     nibble = 4'hD;
            SEG_E:     nibble = 4'hE;
            SEG_F:     nibble = 4'hF;
            SEG_BLANK: is_blank = 1'b1;
            default:   is_invalid = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_display_capture.sv
// Reader side of the 8-digit multiplexed seven-segment display. Samples the
// anode/segment bus, waits for each (anode, pattern) pair to hold for
// STABLE_CYCLES, decodes the glyph into a per-digit shadow and commits the
// whole 32-bit value once every digit has been seen.
//
// Optional build macro: SEG7_DIRECTION_DETECT_EN enables up/down count
// direction detection between consecutive committed frames. Without it,
// dir_down and dir_valid are tied low.
module seg7_display_capture #(
    parameter int STABLE_CYCLES = 4,
    parameter int NUM_DIGITS    = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    seg7_display_capture_if.slave     disp,
    output logic [4*NUM_DIGITS-1:0]   value,
    output logic [NUM_DIGITS-1:0]     blank_mask,
    output logic                      frame_valid,
    output logic                      seg_error,
    output logic                      anode_error,
    output logic                      dir_down,
    output logic                      dir_valid
);

    import seg7_pkg::*;

    localparam logic [7:0] STABLE_W = 8'(STABLE_CYCLES);

    // Stage 1: registered, active-high copies of the bus
    seg_t                  pat_r;
    logic [NUM_DIGITS-1:0] sel_r;

    // Stage 2: previous-cycle copy, stability counter and capture flag
    seg_t                  pat_p;
    logic [NUM_DIGITS-1:0] sel_p;
    logic [7:0]            cnt;
    logic [7:0]            cnt_n;
    logic                  cap_flag;
    logic                  cap_flag_n;
    logic                  same;
    logic                  fire;
    logic                  fire_single;
    logic                  fire_multi;
    int unsigned           ones;

    // Decode and frame assembly
    logic [2:0]              cap_idx;
    nibble_t                 dec_nibble;
    logic                    dec_blank;
    logic                    dec_invalid;
    logic                    cap_ok;
    logic                    seg_err_n;
    logic                    commit;
    logic [NUM_DIGITS-1:0]   seen;
    logic [NUM_DIGITS-1:0]   seen_set;
    logic [4*NUM_DIGITS-1:0] shadow_val;
    logic [NUM_DIGITS-1:0]   shadow_blank;

    // Register the bus and flip it to active-high.
    always_ff @(posedge clk) begin
        if (reset) begin
            pat_r <= '0;
            sel_r <= '0;
        end else begin
            pat_r <= ~{disp.segG, disp.segF, disp.segE, disp.segD,
                       disp.segC, disp.segB, disp.segA};
            sel_r <= ~{disp.an7, disp.an6, disp.an5, disp.an4,
                       disp.an3, disp.an2, disp.an1, disp.an0};
        end
    end

    // Stability count and one-shot fire per dwell; a blanking gap (no anode)
    // clears the count so the next digit always starts fresh.
    always_comb begin
        ones       = $countones(sel_r);
        same       = (sel_r == sel_p) && (pat_r == pat_p);
        cnt_n      = 8'd0;
        fire       = 1'b0;
        cap_flag_n = 1'b0;
        if (ones != 0) begin
            if (same && (cnt != 8'd0)) begin
                cnt_n = (cnt >= STABLE_W) ? STABLE_W : cnt + 8'd1;
            end else begin
                cnt_n = 8'd1;
            end
            fire       = (cnt_n == STABLE_W) && !(cap_flag && same);
            cap_flag_n = fire || (cap_flag && same);
        end
        fire_single = fire && (ones == 1);
        fire_multi  = fire && (ones > 1);
    end

    // Stability tracking registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pat_p    <= '0;
            sel_p    <= '0;
            cnt      <= 8'd0;
            cap_flag <= 1'b0;
        end else begin
            pat_p    <= pat_r;
            sel_p    <= sel_r;
            cnt      <= cnt_n;
            cap_flag <= cap_flag_n;
        end
    end

    seg7_pattern_decode u_decode (
        .pat        (pat_r),
        .nibble     (dec_nibble),
        .is_blank   (dec_blank),
        .is_invalid (dec_invalid)
    );

    // Capture qualification and the seen bit for the captured digit.
    always_comb begin
        cap_idx   = onehot_index(sel_r);
        cap_ok    = fire_single && !dec_invalid;
        seg_err_n = fire_single && dec_invalid;
        commit    = (seen == '1);
        seen_set  = '0;
        if (cap_ok) seen_set[cap_idx] = 1'b1;
    end

    // Shadow write, seen tracking, commit and error pulses. On a commit the
    // seen mask is cleared before the concurrent capture's bit is applied, so
    // that digit counts toward the next frame while value takes the
    // pre-capture shadow.
    always_ff @(posedge clk) begin
        if (reset) begin
            seen         <= '0;
            shadow_val   <= '0;
            shadow_blank <= '0;
            value        <= '0;
            blank_mask   <= '0;
            frame_valid  <= 1'b0;
            seg_error    <= 1'b0;
            anode_error  <= 1'b0;
        end else begin
            seen        <= (commit ? '0 : seen) | seen_set;
            frame_valid <= commit;
            seg_error   <= seg_err_n;
            anode_error <= fire_multi;
            if (cap_ok) begin
                shadow_val[{cap_idx, 2'b00} +: 4] <= dec_nibble;
                shadow_blank[cap_idx]             <= dec_blank;
            end
            if (commit) begin
                value      <= shadow_val;
                blank_mask <= shadow_blank;
            end
        end
    end

`ifdef SEG7_DIRECTION_DETECT_EN
    logic [4*NUM_DIGITS-1:0] prev_val;
    logic                    have_prev;

    // Compare each fully lit frame against the previous fully lit one; frames
    // with blank digits neither compare nor replace the reference.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_val  <= '0;
            have_prev <= 1'b0;
            dir_down  <= 1'b0;
            dir_valid <= 1'b0;
        end else begin
            dir_valid <= 1'b0;
            if (commit && (shadow_blank == '0)) begin
                if (have_prev) begin
                    if (shadow_val == prev_val + 1'b1) begin
                        dir_valid <= 1'b1;
                        dir_down  <= 1'b0;
                    end else if (shadow_val == prev_val - 1'b1) begin
                        dir_valid <= 1'b1;
                        dir_down  <= 1'b1;
                    end
                end
                prev_val  <= shadow_val;
                have_prev <= 1'b1;
            end
        end
    end
`else
    assign dir_down  = 1'b0;
    assign dir_valid = 1'b0;
`endif

endmodule

// File: tb/tb_seg7_display_capture.sv
// Directed bench for seg7_display_capture with STABLE_CYCLES = 4.
// Drives the active-low display bus digit by digit and checks the committed
// frames, error pulses and (build-dependent) direction outputs.
module tb_seg7_display_capture;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  an_v;      // active-low anodes, bit i = anI
    logic [6:0]  seg_on;    // active-high pattern, gfedcba

    logic [31:0] value;
    logic [7:0]  blank_mask;
    logic        frame_valid, seg_error, anode_error, dir_down, dir_valid;

    int tests = 0;
    int fails = 0;
    int fv_cnt = 0, se_cnt = 0, ae_cnt = 0, dv_cnt = 0;
    int fv0, se0, ae0;

`ifdef SEG7_DIRECTION_DETECT_EN
    localparam int EXP_DIR_AFTER_9 = 1;
    localparam int EXP_DIR_AFTER_A = 2;
    localparam int EXP_DOWN_AFTER_9 = 1;
`else
    localparam int EXP_DIR_AFTER_9 = 0;
    localparam int EXP_DIR_AFTER_A = 0;
    localparam int EXP_DOWN_AFTER_9 = 0;
`endif

    always #5 clk = ~clk;

    seg7_display_capture_if bus ();

    assign bus.segA = ~seg_on[0];
    assign bus.segB = ~seg_on[1];
    assign bus.segC = ~seg_on[2];
    assign bus.segD = ~seg_on[3];
    assign bus.segE = ~seg_on[4];
    assign bus.segF = ~seg_on[5];
    assign bus.segG = ~seg_on[6];
    assign bus.an0  = an_v[0];
    assign bus.an1  = an_v[1];
    assign bus.an2  = an_v[2];
    assign bus.an3  = an_v[3];
    assign bus.an4  = an_v[4];
    assign bus.an5  = an_v[5];
    assign bus.an6  = an_v[6];
    assign bus.an7  = an_v[7];

    seg7_display_capture #(.STABLE_CYCLES(4), .NUM_DIGITS(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .disp        (bus),
        .value       (value),
        .blank_mask  (blank_mask),
        .frame_valid (frame_valid),
        .seg_error   (seg_error),
        .anode_error (anode_error),
        .dir_down    (dir_down),
        .dir_valid   (dir_valid)
    );

    // Pulse counters, sampled on the falling edge.
    always @(negedge clk) begin
        if (frame_valid) fv_cnt++;
        if (seg_error)   se_cnt++;
        if (anode_error) ae_cnt++;
        if (dir_valid)   dv_cnt++;
    end

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: return 7'h3F;  4'h1: return 7'h06;
            4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;
            4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;
            4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;
            4'hE: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        an_v   = 8'hFF;
        seg_on = 7'h00;
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input logic [7:0] an_low, input logic [6:0] pat, input int n);
        an_v   = an_low;
        seg_on = pat;
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_digit(input int idx, input logic [6:0] pat, input int n);
        logic [7:0] a;
        a      = 8'hFF;
        a[idx] = 1'b0;
        drive(a, pat, n);
    endtask

    task automatic drive_frame(input logic [31:0] v);
        for (int i = 0; i < 8; i++) drive_digit(i, glyph(v[4*i +: 4]), 6);
        idle(6);
    endtask

    initial begin
        reset  = 1'b1;
        an_v   = 8'hFF;
        seg_on = 7'h00;
        repeat (3) @(negedge clk);
        chk("rst_value", value, 32'h0);
        chk("rst_blank", {24'h0, blank_mask}, 32'h0);
        chk("rst_fv", {31'h0, frame_valid}, 32'h0);
        chk("rst_seg_err", {31'h0, seg_error}, 32'h0);
        chk("rst_an_err", {31'h0, anode_error}, 32'h0);
        chk("rst_dir", {30'h0, dir_down, dir_valid}, 32'h0);
        reset = 1'b0;
        idle(2);

        // Basic frame: digits 8,7,6,5,4,3,2,1 from an0 upward.
        fv0 = fv_cnt;
        drive_frame(32'h12345678);
        chk("f1_count", fv_cnt - fv0, 1);
        chk("f1_value", value, 32'h12345678);
        chk("f1_blank", {24'h0, blank_mask}, 32'h0);

        // Digit 3 dwell too short: no commit until it is re-driven long enough.
        fv0 = fv_cnt;
        drive_digit(0, 7'h06, 6);
        drive_digit(1, 7'h5B, 6);
        drive_digit(2, 7'h4F, 6);
        drive_digit(3, 7'h7F, 3);
        drive_digit(4, 7'h6D, 6);
        drive_digit(5, 7'h7D, 6);
        drive_digit(6, 7'h07, 6);
        drive_digit(7, 7'h7F, 6);
        idle(6);
        chk("short_no_commit", fv_cnt - fv0, 0);
        chk("short_value_held", value, 32'h12345678);
        drive_digit(3, 7'h7F, 6);
        idle(6);
        chk("short_commit", fv_cnt - fv0, 1);
        chk("short_value", value, 32'h87658321);

        // Illegal glyph on digit 2, blank on digit 6.
        fv0 = fv_cnt;
        se0 = se_cnt;
        drive_digit(0, 7'h3F, 6);
        drive_digit(1, 7'h6F, 6);
        drive_digit(2, 7'h49, 6);
        drive_digit(3, 7'h77, 6);
        drive_digit(4, 7'h7C, 6);
        drive_digit(5, 7'h39, 6);
        drive_digit(6, 7'h00, 6);
        drive_digit(7, 7'h71, 6);
        idle(6);
        chk("seg_err_pulses", se_cnt - se0, 1);
        chk("seg_err_no_commit", fv_cnt - fv0, 0);
        drive_digit(2, 7'h5E, 6);
        idle(6);
        chk("seg_err_commit", fv_cnt - fv0, 1);
        chk("blank_value", value, 32'hF0CBAD90);
        chk("blank_mask", {24'h0, blank_mask}, 32'h0000_0040);

        // Two anodes together: one anode_error, nothing captured.
        fv0 = fv_cnt;
        ae0 = ae_cnt;
        drive(8'hFC, 7'h06, 6);
        idle(6);
        chk("an_err_pulses", ae_cnt - ae0, 1);
        for (int i = 2; i < 8; i++) drive_digit(i, 7'h3F, 6);
        idle(6);
        chk("an_err_seen_clear", fv_cnt - fv0, 0);
        drive_digit(0, 7'h77, 6);
        drive_digit(1, 7'h3F, 6);
        idle(6);
        chk("an_err_commit", fv_cnt - fv0, 1);
        chk("frame_A", value, 32'h0000000A);

        // Count down A -> 9, then up 9 -> A.
        drive_frame(32'h00000009);
        chk("frame_9", value, 32'h00000009);
        chk("dir_pulses_9", dv_cnt, EXP_DIR_AFTER_9);
        chk("dir_down_9", {31'h0, dir_down}, EXP_DOWN_AFTER_9);
        drive_frame(32'h0000000A);
        chk("dir_pulses_A", dv_cnt, EXP_DIR_AFTER_A);
        chk("dir_down_A", {31'h0, dir_down}, 32'h0);

        // Reset after five captured digits discards the partial frame.
        for (int i = 0; i < 5; i++) drive_digit(i, 7'h06, 6);
        idle(1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_value", value, 32'h0);
        chk("mid_rst_outs", {24'h0, blank_mask, frame_valid, seg_error, anode_error, dir_down, dir_valid}
                            & 32'h0000_1FFF, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_value", value, 32'h0);
        chk("post_rst_fv", {31'h0, frame_valid}, 32'h0);
        fv0 = fv_cnt;
        drive_digit(5, glyph(4'h5), 6);
        drive_digit(6, glyph(4'h3), 6);
        drive_digit(7, glyph(4'h1), 6);
        idle(6);
        chk("post_rst_partial", fv_cnt - fv0, 0);
        drive_digit(0, glyph(4'hF), 6);
        drive_digit(1, glyph(4'hD), 6);
        drive_digit(2, glyph(4'hB), 6);
        drive_digit(3, glyph(4'h9), 6);
        drive_digit(4, glyph(4'h7), 6);
        idle(6);
        chk("post_rst_commit", fv_cnt - fv0, 1);
        chk("post_rst_frame", value, 32'h13579BDF);
        chk("post_rst_blank", {24'h0, blank_mask}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seg7_display_capture.md
Name: seg7_display_capture

Overview:
Reader side of the 8-digit multiplexed seven-segment display interface. It samples the active-low anode and segment lines driven by the display counter block and decodes each digit's segment pattern back to a hex nibble. It reassembles the full 32-bit displayed value and signals each completed frame. It sits beside the display driver for self-checking and loopback monitoring on board and in simulation.

Parameters:
STABLE_CYCLES, 4, consecutive cycles an (anode, pattern) pair must hold before it is accepted; legal range 1..255.
NUM_DIGITS, 8, number of multiplexed digits; fixed at 8 for this revision.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
segA..segG  input  1 each  segment lines, active-low (0 = lit)
an0..an7  input  1 each  digit anodes, active-low (0 = digit selected)
value  output  32  last completed frame; digit i occupies bits [4i+3:4i]; an0 = digit 0 (LSN)
blank_mask  output  8  bit i = 1: digit i was blank (all segments off) in the last frame
frame_valid  output  1  one-cycle pulse when value/blank_mask update
seg_error  output  1  one-cycle pulse: stable pattern is neither blank nor a legal hex glyph
anode_error  output  1  one-cycle pulse: more than one anode active for STABLE_CYCLES
dir_down  output  1  optional feature; see below
dir_valid  output  1  optional feature; see below

Behaviour:
- Reset is synchronous and active-high. On reset, all outputs are 0, and the shadow registers, seen mask, stability counter and capture flag are cleared. Reset mid-frame discards the partial frame.
- Stage 1: all inputs are registered and inverted to active-high. pat = {g,f,e,d,c,b,a}; sel = 8-bit anode vector.
- Stage 2 classification:
  - popcount(sel) = 0: blanking gap; counter cleared; nothing captured.
  - popcount(sel) = 1: idx = one-hot index.
  - popcount(sel) > 1: counter runs on the sel vector; anode_error pulses once per dwell when the count reaches STABLE_CYCLES; nothing captured.
- Stability counter: increments while sel and pat are unchanged from the previous cycle. It resets to 1 on any change and saturates at STABLE_CYCLES.
- Capture fires exactly once per dwell, on the cycle the count first equals STABLE_CYCLES. The capture flag blocks repeats until sel or pat changes.
- Decode (hex glyphs): 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7, 7F→8, 6F→9, 77→A, 7C→b, 39→C, 5E→d, 79→E, 71→F.
  - 00 → blank: nibble 0, blank bit set.
  - Any other pattern → seg_error pulse; seen bit untouched.
- On a valid capture: shadow[idx] is written (nibble and blank bit) and seen[idx] is set. Re-capturing an already-seen digit overwrites it silently.
- Commit: the cycle after seen becomes 8'hFF:
  - value and blank_mask are loaded from shadow;
  - frame_valid = 1 for that cycle;
  - seen is cleared.
- Latency: 2 cycles of input registering/classification, plus STABLE_CYCLES to capture, plus 1 cycle to commit.
- Simultaneous capture and commit: clear is applied first, then the new capture's seen bit is set. The new digit belongs to the next frame; the commit uses the pre-capture shadow.
- value and blank_mask hold between commits. Error pulses never block commits.

Optional Feature:
SEG7_DIRECTION_DETECT_EN
- Defined:
  - On each commit after the first, compare the new value with the previous one (mod 2^32). dir_valid pulses with frame_valid.
  - new = prev+1 → dir_down = 0; new = prev−1 → dir_down = 1.
  - Any other delta (including equal) → dir_valid stays 0 and dir_down holds its last value.
  - Frames containing any blank digit are excluded from the comparison.
  - A 32-bit prev register and a first-frame flag are added; both are cleared on reset.
- Undefined: dir_down and dir_valid are tied to 0. The ports remain present.

Decomposition:
- Shared package seg7_pkg contains:
  - typedef seg_t (logic [6:0], gfedcba order);
  - localparams for the 16 glyph constants and SEG_BLANK;
  - NUM_DIGITS;
  - typedef nibble_t.
- The display driver block imports the same package.
- Sub-module seg7_pattern_decode: combinational seg_t → {nibble, is_blank, is_invalid}. It is instantiated once.

Test Plan:
- Drive 8 digits, one-hot anodes, 6 cycles each, patterns for 1,2,3,4,5,6,7,8 (an0 = 8) → one frame_valid; value = 32'h12345678; blank_mask = 0.
- Hold an3 with pattern 7'h7F for only 3 cycles (STABLE_CYCLES = 4), other digits valid → no frame_valid until digit 3 is driven ≥4 cycles.
- Drive an2 with pattern 7'h49 for 6 cycles → seg_error single pulse; frame is not committed until digit 2 receives a legal glyph.
- Assert an0 and an1 together for 6 cycles → exactly one anode_error pulse; seen unchanged.
- Complete frame 32'h0000000A, then frame 32'h00000009 with SEG7_DIRECTION_DETECT_EN defined → second commit gives dir_valid = 1, dir_down = 1. Without the macro → dir_valid stays 0.
- Assert reset after 5 digits captured, then drive 8 full digits → a single frame_valid reflecting only post-reset digits; all outputs are 0 during and immediately after reset.
